// File: rtl/booth_mul_ctrl.sv
// Iterative radix-4 Booth multiplier sequencer (MUL/MULH/MULHSU/MULHU/MULW).
// Define MUL_EARLY_OUT_EN to finish as soon as all remaining Booth digits are zero.
module booth_mul_ctrl #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ITER_D = 33,
    parameter int unsigned ITER_W = 17
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [1:0]      io_in_op,
    input  logic            io_in_word,
    input  logic [XLEN-1:0] io_src1,
    input  logic [XLEN-1:0] io_src2,
    input  logic            io_flush,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [XLEN-1:0] io_result,
    output logic            io_busy
);

    localparam int unsigned AccW = 2 * XLEN;
    localparam int unsigned MplW = XLEN + 3;
    localparam int unsigned CntW = $clog2(ITER_D + 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [AccW-1:0]     acc_q, acc_d;
    // Multiplicand kept at accumulator width: bits above 2^128 never reach the sum.
    logic [AccW-1:0]     m_q, m_d;
    logic [MplW-1:0]     mpl_q, mpl_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic                word_q, word_d;

    logic                src1_signed, src2_signed;
    logic [AccW-1:0]     m_init;
    logic [MplW-1:0]     mpl_init;
    logic [AccW-1:0]     pp;
    logic                cin;
    logic [AccW-1:0]     acc_sum;
    logic [MplW-1:0]     mpl_shift;
    logic                early_done;
    logic [XLEN-1:0]     result_sel;

    always_comb begin
        src1_signed = io_in_word | (io_in_op != 2'b11);
        src2_signed = io_in_word | (io_in_op == 2'b00) | (io_in_op == 2'b01);
        if (io_in_word) begin
            m_init   = {{(AccW-32){io_src1[31]}}, io_src1[31:0]};
            mpl_init = {{(MplW-33){io_src2[31]}}, io_src2[31:0], 1'b0};
        end else begin
            m_init   = {{(AccW-XLEN){src1_signed & io_src1[XLEN-1]}}, io_src1};
            mpl_init = {{2{src2_signed & io_src2[XLEN-1]}}, io_src2, 1'b0};
        end
    end

    // Booth digit from {y[i+1], y[i], y[i-1]}; negation is ~pp with carry-in.
    always_comb begin
        pp  = '0;
        cin = 1'b0;
        unique case (mpl_q[2:0])
            3'b001, 3'b010: pp = m_q;
            3'b011:         pp = {m_q[AccW-2:0], 1'b0};
            3'b100: begin
                pp  = ~{m_q[AccW-2:0], 1'b0};
                cin = 1'b1;
            end
            3'b101, 3'b110: begin
                pp  = ~m_q;
                cin = 1'b1;
            end
            default: pp = '0;
        endcase
        acc_sum   = acc_q + pp + AccW'(cin);
        mpl_shift = {{2{mpl_q[MplW-1]}}, mpl_q[MplW-1:2]};
    end

`ifdef MUL_EARLY_OUT_EN
    assign early_done = (mpl_shift == '0) || (&mpl_shift);
`else
    assign early_done = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        mpl_d   = mpl_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        word_d  = word_q;
        unique case (state_q)
            StIdle: begin
                if (io_in_valid && !io_flush) begin
                    state_d = StBusy;
                    acc_d   = '0;
                    m_d     = m_init;
                    mpl_d   = mpl_init;
                    cnt_d   = io_in_word ? CntW'(ITER_W) : CntW'(ITER_D);
                    op_d    = io_in_op;
                    word_d  = io_in_word;
                end
            end
            StBusy: begin
                if (io_flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = acc_sum;
                    m_d   = {m_q[AccW-3:0], 2'b00};
                    mpl_d = mpl_shift;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1) || early_done) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (io_flush || io_out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            m_q     <= '0;
            mpl_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            mpl_q   <= mpl_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        if (word_q) begin
            result_sel = {{(XLEN-32){acc_q[31]}}, acc_q[31:0]};
        end else if (op_q == 2'b00) begin
            result_sel = acc_q[XLEN-1:0];
        end else begin
            result_sel = acc_q[AccW-1:XLEN];
        end
    end

    assign io_in_ready  = (state_q == StIdle);
    assign io_out_valid = (state_q == StDone);
    assign io_result    = (state_q == StDone) ? result_sel : '0;
    assign io_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: directed plan cases plus random ops vs a product model.
module tb_booth_mul_ctrl;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [1:0]  io_in_op;
    logic        io_in_word;
    logic [63:0] io_src1;
    logic [63:0] io_src2;
    logic        io_flush;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [63:0] io_result;
    logic        io_busy;

    int checks;
    int errors;

    booth_mul_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .io_in_valid (io_in_valid),
        .io_in_ready (io_in_ready),
        .io_in_op    (io_in_op),
        .io_in_word  (io_in_word),
        .io_src1     (io_src1),
        .io_src2     (io_src2),
        .io_flush    (io_flush),
        .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready),
        .io_result   (io_result),
        .io_busy     (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Full-precision product of the extended operands, then the architectural slice.
    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] x, y, p;
        if (word) begin
            x = {{96{a[31]}}, a[31:0]};
            y = {{96{b[31]}}, b[31:0]};
            p = x * y;
            return {{32{p[31]}}, p[31:0]};
        end
        x = (op == 2'b11) ? {64'd0, a} : {{64{a[63]}}, a};
        y = (op <= 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
        p = x * y;
        return (op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic word,
                            input logic [63:0] a, input logic [63:0] b);
        @(negedge clock);
        chk("in_ready_idle", 64'(io_in_ready), 64'd1);
        io_in_valid = 1'b1;
        io_in_op    = op;
        io_in_word  = word;
        io_src1     = a;
        io_src2     = b;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int hold);
        int n;
        int lat;
        logic [63:0] r0;
        n = word ? 17 : 33;
        start_op(op, word, a, b);
        chk("busy_after_accept", 64'(io_busy), 64'd1);
        lat = 0;
        while (!io_out_valid && lat < 40) begin
            @(posedge clock);
            lat++;
            #1;
        end
`ifdef MUL_EARLY_OUT_EN
        chk("latency_bound", 64'(lat >= 1 && lat <= n), 64'd1);
`else
        chk("latency", 64'(lat), 64'(n));
`endif
        chk("result", io_result, exp);
        chk("in_ready_done", 64'(io_in_ready), 64'd0);
        r0 = io_result;
        repeat (hold) begin
            @(posedge clock);
            #1;
            chk("hold_result", io_result, r0);
            chk("hold_valid", 64'(io_out_valid), 64'd1);
            chk("hold_in_ready", 64'(io_in_ready), 64'd0);
        end
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        chk("post_valid", 64'(io_out_valid), 64'd0);
        chk("post_result", io_result, 64'd0);
        chk("post_in_ready", 64'(io_in_ready), 64'd1);
        chk("post_busy", 64'(io_busy), 64'd0);
    endtask

    initial begin
        logic seen;
        logic [1:0]  rop;
        logic        rword;
        logic [63:0] ra, rb;
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_in_op     = 2'b00;
        io_in_word   = 1'b0;
        io_src1      = '0;
        io_src2      = '0;
        io_flush     = 1'b0;
        io_out_ready = 1'b0;

        #2;
        chk("rst_in_ready", 64'(io_in_ready), 64'd1);
        chk("rst_out_valid", 64'(io_out_valid), 64'd0);
        chk("rst_result", io_result, 64'd0);
        chk("rst_busy", 64'(io_busy), 64'd0);
        #21;
        reset = 1'b1;

        do_op(2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 0);
        do_op(2'b11, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        do_op(2'b01, 1'b0, '1, '1, 64'h0, 0);
        do_op(2'b00, 1'b0, '1, '1, 64'h1, 0);
        do_op(2'b10, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h4000_0000_0000_0000, 0);
        do_op(2'b00, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF, 64'hDEAD_BEEF_0000_0002,
              64'hFFFF_FFFF_FFFF_FFFE, 0);

        // Backpressure then an immediate back-to-back op.
        do_op(2'b00, 1'b0, 64'd123456789, 64'd987654321, 64'd121932631112635269, 5);
        do_op(2'b11, 1'b0, 64'd5, 64'd11, 64'd0, 0);

        // Request with flush in IDLE must not be accepted.
        @(negedge clock);
        io_in_valid = 1'b1;
        io_flush    = 1'b1;
        io_src1     = 64'd9;
        io_src2     = 64'd9;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        io_flush    = 1'b0;
        chk("idle_flush_busy", 64'(io_busy), 64'd0);

        // Flush during iteration 10.
        start_op(2'b00, 1'b0, 64'd5, 64'd9);
        repeat (9) @(posedge clock);
        #1;
        chk("flush_pre_busy", 64'(io_busy), 64'd1);
        io_flush = 1'b1;
        @(posedge clock);
        #1;
        io_flush = 1'b0;
        chk("flush_busy", 64'(io_busy), 64'd0);
        chk("flush_in_ready", 64'(io_in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (io_out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);
        do_op(2'b00, 1'b0, 64'd7, 64'd6, 64'd42, 0);

        // Asynchronous reset mid-operation.
        start_op(2'b01, 1'b0, '1, 64'd77);
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(io_busy), 64'd0);
        chk("mid_rst_valid", 64'(io_out_valid), 64'd0);
        chk("mid_rst_result", io_result, 64'd0);
        chk("mid_rst_in_ready", 64'(io_in_ready), 64'd1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_in_ready", 64'(io_in_ready), 64'd1);
        do_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ref_mul(2'b10, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFE, 64'd3), 0);

        for (int i = 0; i < 24; i++) begin
            rop   = 2'($urandom_range(0, 3));
            rword = 1'($urandom_range(0, 1));
            ra    = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = 64'h8000_0000_0000_0000;
                1:       rb = '1;
                2:       rb = 64'($urandom_range(0, 15));
                default: rb = {$urandom, $urandom};
            endcase
            do_op(rop, rword, ra, rb, ref_mul(rop, rword, ra, rb), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
